// File: rtl/restor_div_pkg.sv
// Shared constants and state type for the restoring-division controller.
package restor_div_pkg;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/restoring_division_controller.sv
// Sequencing FSM for the restoring-division datapath: operand handshake, datapath
// load/feed/gate controls, result capture and divide-by-zero bypass.
module restoring_division_controller
   import restor_div_pkg::*;
#(
   parameter int unsigned WIDTH     = restor_div_pkg::WIDTH,
   parameter int unsigned CNT_WIDTH = restor_div_pkg::CNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             src_valid,
   output logic             src_ready,
   input  logic [WIDTH-1:0] src_dividend,
   input  logic [WIDTH-1:0] src_divisor,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_quotient,
   output logic [WIDTH-1:0] res_remainder,
   output logic             res_div_by_zero,
   output logic             busy,
   output logic [WIDTH-1:0] dp_dividend,
   output logic [WIDTH-1:0] dp_divisor,
   output logic             dp_dividend_en,
   output logic             dp_divisor_en,
   output logic             dp_dividend_mux_sel,
   output logic             dp_counted_max,
   input  logic [WIDTH-1:0] dp_quotient,
   input  logic [WIDTH-1:0] dp_remainder,
   input  logic             dp_counted
);

   // The datapath iterates once per counter step, so its counter must span WIDTH.
   if ((1 << CNT_WIDTH) != WIDTH) begin : g_width_check
      $error("restoring_division_controller: 2**CNT_WIDTH must equal WIDTH");
   end

   div_state_t state_q, state_d;
   logic       accept;
   logic       div_zero;

   assign src_ready   = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign res_valid   = (state_q == DONE);
   assign accept      = src_valid & src_ready;
   assign div_zero    = (src_divisor == '0);
   assign dp_dividend = src_dividend;
   assign dp_divisor  = src_divisor;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = div_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (dp_counted) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath controls; counted_max stays high outside CALC so the accumulator idles at 0
   always_comb begin
      dp_dividend_en      = 1'b0;
      dp_divisor_en       = 1'b0;
      dp_dividend_mux_sel = 1'b0;
      dp_counted_max      = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (accept && !div_zero) begin
               dp_divisor_en       = 1'b1;
               dp_dividend_en      = 1'b1;
               dp_dividend_mux_sel = 1'b1;
            end
         end
         CALC: begin
            dp_counted_max = dp_counted;
            dp_dividend_en = ~dp_counted;
         end
         default: ;
      endcase
   end

   // Result holding registers: bypass load on divide-by-zero, capture on final count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         res_quotient    <= '0;
         res_remainder   <= '0;
         res_div_by_zero <= 1'b0;
      end else if (accept && div_zero) begin
         res_quotient    <= '1;
         res_remainder   <= src_dividend;
         res_div_by_zero <= 1'b1;
      end else if ((state_q == CALC) && dp_counted) begin
         res_quotient    <= dp_quotient;
         res_remainder   <= dp_remainder;
         res_div_by_zero <= 1'b0;
      end
   end

endmodule

// File: tb/tb_restoring_division_controller.sv
// Directed bench for restoring_division_controller with a behavioural datapath.
module tb_restoring_division_controller;

   localparam int unsigned W = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [W-1:0]  src_dividend = '0;
   logic [W-1:0]  src_divisor = '0;
   logic          res_valid;
   logic          res_ready = 1'b1;
   logic [W-1:0]  res_quotient;
   logic [W-1:0]  res_remainder;
   logic          res_div_by_zero;
   logic          busy;
   logic [W-1:0]  dp_dividend;
   logic [W-1:0]  dp_divisor;
   logic          dp_dividend_en;
   logic          dp_divisor_en;
   logic          dp_dividend_mux_sel;
   logic          dp_counted_max;
   logic [W-1:0]  dp_quotient;
   logic [W-1:0]  dp_remainder;
   logic          dp_counted;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   restoring_division_controller #(.WIDTH(W), .CNT_WIDTH(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .src_valid           (src_valid),
      .src_ready           (src_ready),
      .src_dividend        (src_dividend),
      .src_divisor         (src_divisor),
      .res_valid           (res_valid),
      .res_ready           (res_ready),
      .res_quotient        (res_quotient),
      .res_remainder       (res_remainder),
      .res_div_by_zero     (res_div_by_zero),
      .busy                (busy),
      .dp_dividend         (dp_dividend),
      .dp_divisor          (dp_divisor),
      .dp_dividend_en      (dp_dividend_en),
      .dp_divisor_en       (dp_divisor_en),
      .dp_dividend_mux_sel (dp_dividend_mux_sel),
      .dp_counted_max      (dp_counted_max),
      .dp_quotient         (dp_quotient),
      .dp_remainder        (dp_remainder),
      .dp_counted          (dp_counted)
   );

   // Behavioural restoring-division datapath driven by the controller
   logic [W:0]   acc_q;
   logic [W-1:0] qr_q;
   logic [W-1:0] dvs_q;
   logic [3:0]   cnt_q;
   logic         counted_q;
   logic [W:0]   shifted;
   logic [W+1:0] diff;
   logic [W:0]   acc_nxt;
   logic [W-1:0] q_nxt;

   always_comb begin
      shifted = {acc_q[W-1:0], qr_q[W-1]};
      diff    = {1'b0, shifted} - {2'b00, dvs_q};
      if (diff[W+1]) begin
         acc_nxt = shifted;
         q_nxt   = {qr_q[W-2:0], 1'b0};
      end else begin
         acc_nxt = diff[W:0];
         q_nxt   = {qr_q[W-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q     <= '0;
         qr_q      <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         counted_q <= 1'b0;
      end else begin
         if (dp_divisor_en) begin
            dvs_q     <= dp_divisor;
            cnt_q     <= '0;
            counted_q <= 1'b0;
         end else begin
            cnt_q     <= cnt_q + 4'd1;
            counted_q <= (cnt_q == 4'd15);
         end
         acc_q <= dp_counted_max ? '0 : acc_nxt;
         if (dp_dividend_en) qr_q <= dp_dividend_mux_sel ? dp_dividend : q_nxt;
      end
   end

   assign dp_counted   = counted_q;
   assign dp_quotient  = dp_counted_max ? qr_q : '0;
   assign dp_remainder = dp_counted_max ? acc_q[W-1:0] : '0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           stall;
      logic [W-1:0] exp_q;
      logic [W-1:0] exp_r;
      logic         exp_dbz;
      int           exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v);
      int n;
      int bad_rdy;
      int bad_hold;
      logic en_exp;
      n = 0;
      while (!src_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("src_ready_before_op", {31'd0, src_ready}, 32'd1);
      en_exp       = (v.b != '0);
      res_ready    = (v.stall == 0);
      src_valid    = 1'b1;
      src_dividend = v.a;
      src_divisor  = v.b;
      #1;
      check("accept_divisor_en", {31'd0, dp_divisor_en}, {31'd0, en_exp});
      check("accept_dividend_en", {31'd0, dp_dividend_en}, {31'd0, en_exp});
      check("accept_mux_sel", {31'd0, dp_dividend_mux_sel}, {31'd0, en_exp});
      check("dp_dividend_copy", {16'd0, dp_dividend}, {16'd0, v.a});
      @(posedge clk); #1;
      src_valid    = 1'b0;
      src_dividend = W'($urandom);
      src_divisor  = W'($urandom);
      n = 1;
      bad_rdy = 0;
      while (!res_valid && n < 100) begin
         if (src_ready || !busy) bad_rdy++;
         @(posedge clk); #1; n++;
      end
      check("latency", n, v.exp_lat);
      check("ready_low_during_op", bad_rdy, 0);
      check("done_no_dp_en", {30'd0, dp_divisor_en, dp_dividend_en}, 32'd0);
      check("quotient", {16'd0, res_quotient}, {16'd0, v.exp_q});
      check("remainder", {16'd0, res_remainder}, {16'd0, v.exp_r});
      check("div_by_zero", {31'd0, res_div_by_zero}, {31'd0, v.exp_dbz});
      if (v.stall > 0) begin
         bad_hold = 0;
         for (int i = 0; i < v.stall; i++) begin
            @(posedge clk); #1;
            if (!res_valid || src_ready || res_quotient !== v.exp_q || res_remainder !== v.exp_r)
               bad_hold++;
         end
         check("stall_hold", bad_hold, 0);
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("valid_drop", {31'd0, res_valid}, 32'd0);
      check("idle_after_hs", {31'd0, src_ready}, 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      int bad;
      vec_t v;
      vecs[0] = '{a: 16'd100,   b: 16'd7,     stall: 0,  exp_q: 16'd14,   exp_r: 16'd2,
                  exp_dbz: 1'b0, exp_lat: 18};
      vecs[1] = '{a: 16'd1234,  b: 16'd0,     stall: 0,  exp_q: 16'hFFFF, exp_r: 16'd1234,
                  exp_dbz: 1'b1, exp_lat: 1};
      vecs[2] = '{a: 16'hFFFF,  b: 16'd1,     stall: 10, exp_q: 16'hFFFF, exp_r: 16'd0,
                  exp_dbz: 1'b0, exp_lat: 18};
      vecs[3] = '{a: 16'hFFFF,  b: 16'd1,     stall: 0,  exp_q: 16'hFFFF, exp_r: 16'd0,
                  exp_dbz: 1'b0, exp_lat: 18};
      vecs[4] = '{a: 16'd5,     b: 16'd10,    stall: 0,  exp_q: 16'd0,    exp_r: 16'd5,
                  exp_dbz: 1'b0, exp_lat: 18};
      vecs[5] = '{a: 16'd40000, b: 16'd256,   stall: 0,  exp_q: 16'd156,  exp_r: 16'd64,
                  exp_dbz: 1'b0, exp_lat: 18};
      vecs[6] = '{a: 16'hFFFF,  b: 16'hFFFF,  stall: 0,  exp_q: 16'd1,    exp_r: 16'd0,
                  exp_dbz: 1'b0, exp_lat: 18};
      vecs[7] = '{a: 16'd0,     b: 16'd3,     stall: 0,  exp_q: 16'd0,    exp_r: 16'd0,
                  exp_dbz: 1'b0, exp_lat: 18};

      // Reset state
      #12;
      check("rst_res_valid", {31'd0, res_valid}, 32'd0);
      check("rst_src_ready", {31'd0, src_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_quotient", {16'd0, res_quotient}, 32'd0);
      check("rst_counted_max", {31'd0, dp_counted_max}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         run_op(vecs[i]);
      end

      // Reset in the 8th CALC cycle of 500/3
      src_valid    = 1'b1;
      src_dividend = 16'd500;
      src_divisor  = 16'd3;
      @(posedge clk); #1;
      src_valid = 1'b0;
      repeat (7) begin
         @(posedge clk); #1;
      end
      check("calc_busy_pre_reset", {31'd0, busy}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("midcalc_rst_ready", {31'd0, src_ready}, 32'd1);
      check("midcalc_rst_valid", {31'd0, res_valid}, 32'd0);
      check("midcalc_rst_q", {16'd0, res_quotient}, 32'd0);
      check("midcalc_rst_r", {16'd0, res_remainder}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      v = '{a: 16'd9, b: 16'd4, stall: 0, exp_q: 16'd2, exp_r: 16'd1, exp_dbz: 1'b0, exp_lat: 18};
      run_op(v);

      // Idle with free-running counter pulses
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (res_valid || busy || !src_ready || dp_divisor_en || dp_dividend_en) bad++;
      end
      check("idle_40_cycles", bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
